// File: rtl/rnn_cell_seq.sv
`default_nettype none
// rnn_cell_seq: serial-load fixed-point recurrent cell, h_t = act(U.x_t + W.h_{t-1}), y_t = act(V.h_t).
// Revision 1.0 - one MAC per matrix row, y sequence streamed after computation.
module rnn_cell_seq #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int DIM    = 3,
  parameter int STEPS  = 3,
  parameter int ACT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_x,
  input  logic [DATA_W-1:0] data_h,
  input  logic [DATA_W-1:0] weight_u,
  input  logic [DATA_W-1:0] weight_w,
  input  logic [DATA_W-1:0] weight_v,
  output logic              out_valid,
  output logic [DATA_W-1:0] out
);

  localparam int PW    = 2 * DATA_W;
  localparam int ACC_W = PW + $clog2(2 * DIM);
  localparam int L     = (DIM * DIM > STEPS * DIM) ? DIM * DIM : STEPS * DIM;
  localparam int LW    = $clog2(L + 1);
  localparam int KW    = $clog2(2 * DIM + 1);
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IW    = (DIM > 1) ? $clog2(DIM) : 1;

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_COMP = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [LW-1:0] ld_cnt;
  logic [KW-1:0] k_cnt;
  logic          phase;      // 0: hidden update, 1: output projection
  logic [SW-1:0] step_cnt;
  logic [SW-1:0] out_step;
  logic [IW-1:0] out_idx;

  logic signed [DATA_W-1:0] u_mem [DIM][DIM];
  logic signed [DATA_W-1:0] w_mem [DIM][DIM];
  logic signed [DATA_W-1:0] v_mem [DIM][DIM];
  logic signed [DATA_W-1:0] x_mem [STEPS][DIM];
  logic signed [DATA_W-1:0] h_mem [DIM];
  logic signed [DATA_W-1:0] y_mem [STEPS][DIM];

  logic signed [ACC_W-1:0]  acc      [DIM];
  logic signed [ACC_W-1:0]  acc_next [DIM];
  logic signed [DATA_W-1:0] a_op     [DIM];
  logic signed [DATA_W-1:0] b_op     [DIM];
  logic signed [PW-1:0]     prod     [DIM];

  logic load_en, ld_last, k_last, comp_done, out_done;

  function automatic logic signed [DATA_W-1:0] act_fn(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC_W;
    if (s > SAT_HI) return SAT_HI[DATA_W-1:0];
    if (ACT == 0) begin
      if (s[ACC_W-1]) return '0;
    end else if (s < SAT_LO) begin
      return SAT_LO[DATA_W-1:0];
    end
    return s[DATA_W-1:0];
  endfunction

  assign load_en   = in_valid && (state == S_IDLE || state == S_LOAD);
  assign ld_last   = (ld_cnt == LW'(L - 1));
  assign k_last    = phase ? (k_cnt == KW'(DIM - 1)) : (k_cnt == KW'(2 * DIM - 1));
  assign comp_done = (state == S_COMP) && phase && k_last && (step_cnt == SW'(STEPS - 1));
  assign out_done  = (state == S_OUT) && (out_step == SW'(STEPS - 1)) && (out_idx == IW'(DIM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (in_valid) next_state = ld_last ? S_COMP : S_LOAD;
      S_LOAD:  if (in_valid && ld_last) next_state = S_COMP;
      S_COMP:  if (comp_done) next_state = S_OUT;
      S_OUT:   if (out_done) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Each row owns one MAC; k walks U/x then W/h in the hidden phase, V/h in the output phase.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
      for (int j = 0; j < DIM; j++) begin
        if (!phase) begin
          if (k_cnt == KW'(j)) begin
            a_op[i] = u_mem[i][j];
            b_op[i] = x_mem[step_cnt][j];
          end
          if (k_cnt == KW'(DIM + j)) begin
            a_op[i] = w_mem[i][j];
            b_op[i] = h_mem[j];
          end
        end else if (k_cnt == KW'(j)) begin
          a_op[i] = v_mem[i][j];
          b_op[i] = h_mem[j];
        end
      end
      prod[i]     = $signed({{DATA_W{a_op[i][DATA_W-1]}}, a_op[i]}) *
                    $signed({{DATA_W{b_op[i][DATA_W-1]}}, b_op[i]});
      acc_next[i] = acc[i] + $signed({{(ACC_W-PW){prod[i][PW-1]}}, prod[i]});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt   <= '0;
      k_cnt    <= '0;
      phase    <= 1'b0;
      step_cnt <= '0;
      out_step <= '0;
      out_idx  <= '0;
      for (int i = 0; i < DIM; i++) acc[i] <= '0;
    end else begin
      if (load_en)               ld_cnt <= ld_last ? '0 : ld_cnt + 1'b1;
      else if (state != S_LOAD)  ld_cnt <= '0;

      if (state == S_COMP) begin
        for (int i = 0; i < DIM; i++) acc[i] <= k_last ? '0 : acc_next[i];
        if (k_last) begin
          k_cnt <= '0;
          phase <= ~phase;
          if (phase) step_cnt <= step_cnt + 1'b1;
        end else begin
          k_cnt <= k_cnt + 1'b1;
        end
      end else begin
        k_cnt    <= '0;
        phase    <= 1'b0;
        step_cnt <= '0;
        for (int i = 0; i < DIM; i++) acc[i] <= '0;
      end

      if (state == S_OUT) begin
        if (out_idx == IW'(DIM - 1)) begin
          out_idx  <= '0;
          out_step <= out_step + 1'b1;
        end else begin
          out_idx <= out_idx + 1'b1;
        end
      end else begin
        out_step <= '0;
        out_idx  <= '0;
      end
    end
  end

  // Storage is never reset; every entry is rewritten by the next burst before use.
  always_ff @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          if (ld_cnt == LW'(i * DIM + j)) begin
            u_mem[i][j] <= weight_u;
            w_mem[i][j] <= weight_w;
            v_mem[i][j] <= weight_v;
          end
        end
        if (ld_cnt == LW'(i)) h_mem[i] <= data_h;
      end
      for (int t = 0; t < STEPS; t++) begin
        for (int j = 0; j < DIM; j++) begin
          if (ld_cnt == LW'(t * DIM + j)) x_mem[t][j] <= data_x;
        end
      end
    end
    if (state == S_COMP && k_last) begin
      for (int i = 0; i < DIM; i++) begin
        if (!phase) h_mem[i] <= act_fn(acc_next[i]);
        else        y_mem[step_cnt][i] <= act_fn(acc_next[i]);
      end
    end
  end

  assign out_valid = (state == S_OUT);
  assign out       = out_valid ? y_mem[out_step][out_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_rnn_cell_seq.sv
`default_nettype none
// tb_rnn_cell_seq: directed bench; an ACT=0 and an ACT=1 instance share every stimulus.
module tb_rnn_cell_seq;

  typedef logic [15:0] mat_t [9];
  typedef logic [15:0] vec_t [3];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] data_x = '0, data_h = '0, weight_u = '0, weight_w = '0, weight_v = '0;
  logic        ov0, ov1;
  logic [15:0] out0, out1;

  int n_cmp = 0;
  int n_err = 0;

  mat_t ident, zero, negi, w2, wmax, perm, vtiny, ones, seqx, halfneg;
  mat_t e_one, e_zero, e_neg, e_rec, e_sat, e_ord, e_tr1, e_tr0;
  vec_t hz, hone, hmax;

  always #5 clk = ~clk;

  rnn_cell_seq #(.DATA_W(16), .FRAC_W(8), .DIM(3), .STEPS(3), .ACT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .data_x(data_x), .data_h(data_h),
    .weight_u(weight_u), .weight_w(weight_w), .weight_v(weight_v),
    .out_valid(ov0), .out(out0)
  );

  rnn_cell_seq #(.DATA_W(16), .FRAC_W(8), .DIM(3), .STEPS(3), .ACT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .data_x(data_x), .data_h(data_h),
    .weight_u(weight_u), .weight_w(weight_w), .weight_v(weight_v),
    .out_valid(ov1), .out(out1)
  );

  // Entered on a negedge; the first beat is presented immediately.
  task automatic drive_burst(input mat_t u, input mat_t w, input mat_t v,
                             input mat_t x, input vec_t h, input int beats);
    for (int n = 0; n < beats; n++) begin
      in_valid = 1'b1;
      weight_u = u[n];
      weight_w = w[n];
      weight_v = v[n];
      data_x   = x[n];
      if (n < 3) data_h = h[n];
      else       data_h = 16'hDEAD;
      @(negedge clk);
    end
    in_valid = 1'b0;
    data_x = 16'hBEEF; data_h = 16'hBEEF;
    weight_u = 16'hBEEF; weight_w = 16'hBEEF; weight_v = 16'hBEEF;
  endtask

  task automatic collect(input string name, input mat_t e0, input mat_t e1);
    int cyc;
    cyc = 0;
    while (ov0 !== 1'b1 && cyc < 200) begin
      n_cmp++;
      if (out0 !== 16'h0 || out1 !== 16'h0 || ov1 !== 1'b0) begin
        n_err++;
        $display("FAIL %s idle: out0=%h out1=%h ov1=%b, expected 0000 0000 0", name, out0, out1, ov1);
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (ov0 !== 1'b1 || cyc > 80) begin
      n_err++;
      $display("FAIL %s latency: waited %0d cycles ov0=%b, expected out_valid within 80", name, cyc, ov0);
      return;
    end
    for (int n = 0; n < 9; n++) begin
      n_cmp++;
      if (ov0 !== 1'b1 || ov1 !== 1'b1 || out0 !== e0[n] || out1 !== e1[n]) begin
        n_err++;
        $display("FAIL %s y[%0d]: ov0=%b out0=%h ov1=%b out1=%h, expected 1 %h 1 %h",
                 name, n, ov0, out0, ov1, out1, e0[n], e1[n]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0 || out0 !== 16'h0 || out1 !== 16'h0) begin
      n_err++;
      $display("FAIL %s tail: ov0=%b out0=%h ov1=%b out1=%h, expected 0 0000 0 0000",
               name, ov0, out0, ov1, out1);
    end
  endtask

  task automatic check_quiet(input string name);
    n_cmp++;
    if (ov0 !== 1'b0 || out0 !== 16'h0 || ov1 !== 1'b0 || out1 !== 16'h0) begin
      n_err++;
      $display("FAIL %s: ov0=%b out0=%h ov1=%b out1=%h, expected 0 0000 0 0000",
               name, ov0, out0, ov1, out1);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_quiet("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("after_reset_release");
  endtask

  task automatic test_identity();
    drive_burst(ident, zero, ident, ones, hz, 9);
    collect("identity", e_one, e_one);
  endtask

  task automatic test_negative();
    drive_burst(negi, zero, ident, ones, hz, 9);
    collect("negative", e_zero, e_neg);
  endtask

  task automatic test_recurrence();
    drive_burst(zero, w2, ident, ones, hone, 9);
    collect("recurrence", e_rec, e_rec);
  endtask

  task automatic test_saturate();
    drive_burst(zero, wmax, ident, ones, hmax, 9);
    collect("saturate", e_sat, e_sat);
  endtask

  task automatic test_order();
    drive_burst(perm, zero, ident, seqx, hz, 9);
    collect("order", e_ord, e_ord);
  endtask

  task automatic test_truncate();
    drive_burst(ident, zero, vtiny, halfneg, hz, 9);
    collect("truncate", e_tr0, e_tr1);
  endtask

  task automatic test_reset_mid();
    int c;
    drive_burst(ident, zero, ident, ones, hz, 4);
    #2 rst_n = 1'b0;
    #1 check_quiet("reset_in_load");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_burst(ident, zero, ident, ones, hz, 9);
    c = 0;
    while (ov0 !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    n_cmp++;
    if (ov0 !== 1'b1 || out0 !== 16'h0100) begin
      n_err++;
      $display("FAIL reset_out_pre: ov0=%b out0=%h, expected 1 0100", ov0, out0);
    end
    #2 rst_n = 1'b0;
    #1 check_quiet("reset_in_out");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_burst(zero, w2, ident, ones, hone, 9);
    collect("after_reset", e_rec, e_rec);
  endtask

  task automatic test_back_to_back();
    drive_burst(ident, zero, ident, ones, hz, 9);
    collect("b2b_first", e_one, e_one);
    drive_burst(zero, w2, ident, ones, hone, 9);
    in_valid = 1'b1;
    weight_u = 16'h1234; weight_w = 16'h4321; weight_v = 16'h7777;
    data_x = 16'h5555; data_h = 16'h6666;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    collect("b2b_second", e_rec, e_rec);
    drive_burst(ident, zero, ident, ones, hz, 9);
    collect("b2b_third", e_one, e_one);
  endtask

  initial begin
    for (int n = 0; n < 9; n++) begin
      zero[n]    = 16'h0000;
      ones[n]    = 16'h0100;
      halfneg[n] = 16'hFF80;
      seqx[n]    = 16'(16 * (n + 1));
      e_one[n]   = 16'h0100;
      e_zero[n]  = 16'h0000;
      e_neg[n]   = 16'hFF00;
      e_sat[n]   = 16'h7FFF;
      e_tr0[n]   = 16'h0000;
      e_tr1[n]   = 16'hFFFF;
      e_rec[n]   = (n < 3) ? 16'h0200 : (n < 6) ? 16'h0400 : 16'h0800;
    end
    ident = '{16'h0100, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0100};
    negi  = '{16'hFF00, 16'h0, 16'h0, 16'h0, 16'hFF00, 16'h0, 16'h0, 16'h0, 16'hFF00};
    w2    = '{16'h0200, 16'h0, 16'h0, 16'h0, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0200};
    wmax  = '{16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h7FFF};
    vtiny = '{16'h0001, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0001};
    // h[0]=x[1], h[1]=x[2], h[2]=x[0]
    perm  = '{16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0100, 16'h0, 16'h0};
    e_ord = '{16'h0020, 16'h0030, 16'h0010, 16'h0050, 16'h0060, 16'h0040,
              16'h0080, 16'h0090, 16'h0070};
    hz    = '{16'h0, 16'h0, 16'h0};
    hone  = '{16'h0100, 16'h0100, 16'h0100};
    hmax  = '{16'h7FFF, 16'h7FFF, 16'h7FFF};

    test_reset();
    test_identity();
    test_negative();
    test_recurrence();
    test_saturate();
    test_order();
    test_truncate();
    test_reset_mid();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
